// File: rtl/shift_load_sequencer.sv
// Upstream driver for the serial-in shift-left/shift-right register stage.
// Accepts a parallel word over valid/ready and plays it out on din with sl or sr
// held high for exactly WIDTH cycles, then pulses done for one cycle.
module shift_load_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   input  logic             abort,
   output logic             sl,
   output logic             sr,
   output logic             din,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // Shadow word, pre-shifted so the next bit to send always sits at one end.
   logic [WIDTH-1:0] data_q, data_d;
   logic             dir_q, dir_d;
   logic             sl_q, sl_d;
   logic             sr_q, sr_d;
   logic             din_q, din_d;
   logic             done_q, done_d;

   // Next-state logic; serial outputs are computed one cycle ahead and registered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      dir_d   = dir_q;
      sl_d    = 1'b0;
      sr_d    = 1'b0;
      din_d   = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // abort is deliberately not looked at here: a coincident word is still taken.
            if (in_valid) begin
               state_d = StShift;
               dir_d   = in_dir;
               cnt_d   = '0;
               sl_d    = ~in_dir;
               sr_d    = in_dir;
               if (in_dir) begin
                  din_d  = in_data[0];
                  data_d = in_data >> 1;
               end else begin
                  din_d  = in_data[WIDTH-1];
                  data_d = in_data << 1;
               end
            end
         end
         StShift: begin
            if (abort) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StDone;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               sl_d  = ~dir_q;
               sr_d  = dir_q;
               if (dir_q) begin
                  din_d  = data_q[0];
                  data_d = data_q >> 1;
               end else begin
                  din_d  = data_q[WIDTH-1];
                  data_d = data_q << 1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset drops all outputs immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         data_q  <= '0;
         dir_q   <= 1'b0;
         sl_q    <= 1'b0;
         sr_q    <= 1'b0;
         din_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         sl_q    <= sl_d;
         sr_q    <= sr_d;
         din_q   <= din_d;
         done_q  <= done_d;
      end
   end

   // Handshake and status decoded from the state register.
   always_comb begin
      in_ready = (state_q == StIdle);
      busy     = (state_q != StIdle);
   end

   assign sl   = sl_q;
   assign sr   = sr_q;
   assign din  = din_q;
   assign done = done_q;

endmodule
